// File: rtl/tick_period_meter_pkg.sv
// Shared tick definitions: meter FSM encoding, default sizes and divider constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tick_period_meter_pkg;

  // Meter state encoding, binary in 2 bits
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  // Default counter width and silence limit for the meter
  localparam int unsigned TICK_WIDTH   = 32;
  localparam int unsigned TICK_TIMEOUT = 1048576;

  // Nominal tick divider length used by the standard tick source
  localparam int unsigned TICK_DIV_LEN = 4;

  // Rising edge: high now, low on the previous cycle
  function automatic logic is_rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// Rising-edge detector for a clk-synchronous input.
// Latency: pulse is combinational in the cycle the input first reads high.
// Backpressure: none; one pulse per low-to-high transition.
module rising_edge_detect
  import tick_period_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic in_q;

  // Previous-cycle copy of the input; resets low so an input already high at release is an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign pulse = is_rise(in, in_q);

endmodule

// File: rtl/tick_period_meter.sv
// Measures edge-to-edge interval of tick_in in clk cycles, with timeout, lock and overrun status.
// Latency: period/period_valid update on the clk edge ending the cycle the input edge is detected.
// Backpressure: period_valid&&out_ready consumes; an unconsumed result is overwritten and overrun set.
module tick_period_meter
  import tick_period_meter_pkg::*;
#(
  parameter int unsigned WIDTH   = TICK_WIDTH,
  parameter int unsigned TIMEOUT = TICK_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             clear,
  input  logic             out_ready,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             timed_out,
  output logic             locked,
  output logic             overrun
);

  localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cnt;
  logic             edge_pulse;
  logic             start;     // first edge after IDLE or TIMEOUT: begin counting, no capture
  logic             capture;   // edge while measuring: report cnt
  logic             expire;    // silence reached the limit
  logic             consume;
  logic             have_prev; // a period has been captured since the last IDLE

  rising_edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (tick_in),
    .pulse (edge_pulse)
  );

  assign consume = period_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle action strobes; clear wins over any edge
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (edge_pulse) begin
            state_nxt = ST_MEASURE;
            start     = 1'b1;
          end
        end
        ST_MEASURE: begin
          if (edge_pulse) begin
            capture = 1'b1;
          end else if (cnt == TIMEOUT_CNT) begin
            state_nxt = ST_TIMEOUT;
            expire    = 1'b1;
          end
        end
        ST_TIMEOUT: begin
          if (edge_pulse) begin
            state_nxt = ST_MEASURE;
            start     = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Interval counter: restarts at 1 on every edge, freezes once the limit is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start || capture) begin
      cnt <= CNT_ONE;
    end else if ((state == ST_MEASURE) && !expire) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Result register and status flags; period is left untouched by consume and clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period       <= '0;
      period_valid <= 1'b0;
      timed_out    <= 1'b0;
      locked       <= 1'b0;
      overrun      <= 1'b0;
      have_prev    <= 1'b0;
    end else if (clear) begin
      period_valid <= 1'b0;
      timed_out    <= 1'b0;
      locked       <= 1'b0;
      overrun      <= 1'b0;
      have_prev    <= 1'b0;
    end else begin
      if (capture) begin
        period       <= cnt;
        period_valid <= 1'b1;
        locked       <= have_prev && (cnt == period);
        have_prev    <= 1'b1;
        if (period_valid && !out_ready) begin
          overrun <= 1'b1;
        end
      end else if (consume) begin
        period_valid <= 1'b0;
      end
      if (expire) begin
        timed_out <= 1'b1;
        locked    <= 1'b0;
      end
      if (start) begin
        timed_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
`timescale 1ns/1ps
module tb_tick_period_meter;
  import tick_period_meter_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick_in = 1'b0;
  logic         clear = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] period, period50;
  logic         period_valid, timed_out, locked, overrun;
  logic         period_valid50, timed_out50, locked50, overrun50;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  tick_period_meter #(.WIDTH(W), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_in      (tick_in),
    .clear        (clear),
    .out_ready    (out_ready),
    .period       (period),
    .period_valid (period_valid),
    .timed_out    (timed_out),
    .locked       (locked),
    .overrun      (overrun)
  );

  tick_period_meter #(.WIDTH(W), .TIMEOUT(50)) dut50 (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_in      (tick_in),
    .clear        (clear),
    .out_ready    (out_ready),
    .period       (period50),
    .period_valid (period_valid50),
    .timed_out    (timed_out50),
    .locked       (locked50),
    .overrun      (overrun50)
  );

  // Advance n clocks; returns 1ns after the last posedge (inputs change and outputs are sampled here)
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle high pulse on tick_in; its edge is acted on at the posedge inside this task
  task automatic pulse();
    tick_in = 1'b1;
    step(1);
    tick_in = 1'b0;
  endtask

  task automatic do_reset(input logic lvl);
    rst_n   = 1'b0;
    tick_in = lvl;
    clear   = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick_in = 1'b0; clear = 1'b0; out_ready = 1'b0;
    step(2);
    checks++; if (period !== 32'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period); end
    checks++; if ({period_valid, timed_out, locked, overrun} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {period_valid, timed_out, locked, overrun}); end
    checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", dut.state); end
    rst_n = 1'b1;
  endtask

  task automatic test_div4();
    do_reset(1'b0);
    out_ready = 1'b1;
    pulse();
    checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL div4_first_edge_valid got=%b exp=0", period_valid); end
    step(TICK_DIV_LEN - 1);
    pulse();
    checks++; if (period !== 32'd4 || period_valid !== 1'b1) begin failures++; $display("FAIL div4_cap1 got=%0d/%b exp=4/1", period, period_valid); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL div4_cap1_locked got=%b exp=0", locked); end
    step(1);
    checks++; if (period_valid !== 1'b0 || period !== 32'd4) begin failures++; $display("FAIL div4_consume got=%0d/%b exp=4/0", period, period_valid); end
    step(2);
    pulse();
    checks++; if (period !== 32'd4 || locked !== 1'b1 || overrun !== 1'b0) begin failures++; $display("FAIL div4_cap2 got=%0d lk=%b ov=%b exp=4 lk=1 ov=0", period, locked, overrun); end
    out_ready = 1'b0;
  endtask

  task automatic test_lock_seq();
    do_reset(1'b0);
    out_ready = 1'b1;
    pulse(); step(4); pulse();
    checks++; if (period !== 32'd5 || locked !== 1'b0) begin failures++; $display("FAIL lock_p1 got=%0d lk=%b exp=5 lk=0", period, locked); end
    step(4); pulse();
    checks++; if (period !== 32'd5 || locked !== 1'b1) begin failures++; $display("FAIL lock_p2 got=%0d lk=%b exp=5 lk=1", period, locked); end
    step(6); pulse();
    checks++; if (period !== 32'd7 || locked !== 1'b0) begin failures++; $display("FAIL lock_p3 got=%0d lk=%b exp=7 lk=0", period, locked); end
    out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset(1'b0);
    out_ready = 1'b1;
    pulse(); step(3); pulse(); step(3); pulse();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL to_prelock got=%b exp=1", locked); end
    step(15);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", timed_out); end
    step(1);
    checks++; if (timed_out !== 1'b1 || locked !== 1'b0) begin failures++; $display("FAIL to_expire got to=%b lk=%b exp to=1 lk=0", timed_out, locked); end
    checks++; if (dut.state !== ST_TIMEOUT) begin failures++; $display("FAIL to_state got=%0d exp=2", dut.state); end
    step(5); pulse();
    checks++; if (timed_out !== 1'b0 || period_valid !== 1'b0 || period !== 32'd4) begin failures++; $display("FAIL to_resume got to=%b v=%b p=%0d exp to=0 v=0 p=4", timed_out, period_valid, period); end
    step(2); pulse();
    checks++; if (period !== 32'd3 || period_valid !== 1'b1) begin failures++; $display("FAIL to_after got=%0d/%b exp=3/1", period, period_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset(1'b0);
    out_ready = 1'b0;
    pulse(); step(5); pulse();
    checks++; if (period !== 32'd6 || period_valid !== 1'b1 || overrun !== 1'b0) begin failures++; $display("FAIL ovr_cap1 got=%0d v=%b ov=%b exp=6 v=1 ov=0", period, period_valid, overrun); end
    step(5); pulse();
    checks++; if (period !== 32'd6 || period_valid !== 1'b1 || overrun !== 1'b1 || locked !== 1'b1) begin failures++; $display("FAIL ovr_cap2 got=%0d v=%b ov=%b lk=%b exp=6 v=1 ov=1 lk=1", period, period_valid, overrun, locked); end
    step(5); pulse();
    checks++; if (period !== 32'd6 || overrun !== 1'b1) begin failures++; $display("FAIL ovr_cap3 got=%0d ov=%b exp=6 ov=1", period, overrun); end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    checks++; if (period_valid !== 1'b0 || period !== 32'd6 || overrun !== 1'b1) begin failures++; $display("FAIL ovr_drain got v=%b p=%0d ov=%b exp v=0 p=6 ov=1", period_valid, period, overrun); end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    out_ready = 1'b0;
    pulse(); step(2); pulse();
    checks++; if (period !== 32'd3 || period_valid !== 1'b1) begin failures++; $display("FAIL b2b_cap1 got=%0d/%b exp=3/1", period, period_valid); end
    step(2);
    out_ready = 1'b1;
    pulse();
    checks++; if (period_valid !== 1'b1 || period !== 32'd3 || overrun !== 1'b0 || locked !== 1'b1) begin failures++; $display("FAIL b2b_same_cycle got v=%b p=%0d ov=%b lk=%b exp v=1 p=3 ov=0 lk=1", period_valid, period, overrun, locked); end
    step(1);
    checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", period_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_held_high();
    do_reset(1'b1);
    step(1);
    checks++; if (timed_out50 !== 1'b0 || period_valid50 !== 1'b0) begin failures++; $display("FAIL hh_start got to=%b v=%b exp 0 0", timed_out50, period_valid50); end
    step(49);
    checks++; if (timed_out50 !== 1'b0) begin failures++; $display("FAIL hh_early got=%b exp=0", timed_out50); end
    step(1);
    checks++; if (timed_out50 !== 1'b1) begin failures++; $display("FAIL hh_expire got=%b exp=1", timed_out50); end
    step(49);
    checks++; if (period_valid50 !== 1'b0 || period50 !== 32'd0 || timed_out50 !== 1'b1 || locked50 !== 1'b0 || overrun50 !== 1'b0) begin failures++; $display("FAIL hh_nocap got v=%b p=%0d to=%b lk=%b ov=%b exp v=0 p=0 to=1 lk=0 ov=0", period_valid50, period50, timed_out50, locked50, overrun50); end
    tick_in = 1'b0;
  endtask

  task automatic test_clear_reset();
    do_reset(1'b0);
    out_ready = 1'b0;
    pulse(); step(2); pulse(); step(2); pulse(); step(2); pulse();
    checks++; if (overrun !== 1'b1 || locked !== 1'b1) begin failures++; $display("FAIL clr_pre got ov=%b lk=%b exp 1 1", overrun, locked); end
    step(2);
    clear = 1'b1; tick_in = 1'b1;
    step(1);
    clear = 1'b0; tick_in = 1'b0;
    checks++; if ({period_valid, timed_out, locked, overrun} !== 4'b0000 || period !== 32'd3) begin failures++; $display("FAIL clr_flags got=%b p=%0d exp=0000 p=3", {period_valid, timed_out, locked, overrun}, period); end
    step(3);
    checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL clr_state got=%0d exp=0", dut.state); end
    pulse();
    checks++; if (dut.state !== ST_MEASURE) begin failures++; $display("FAIL clr_restart got=%0d exp=1", dut.state); end
    step(2);
    rst_n = 1'b0;
    #1;
    checks++; if (dut.state !== ST_IDLE || period !== 32'd0 || {period_valid, timed_out, locked, overrun} !== 4'b0000) begin failures++; $display("FAIL rst_mid got st=%0d p=%0d f=%b exp st=0 p=0 f=0000", dut.state, period, {period_valid, timed_out, locked, overrun}); end
    step(1);
    rst_n = 1'b1;
    pulse();
    checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL rst_first_edge got=%b exp=0", period_valid); end
    step(2); pulse();
    checks++; if (period !== 32'd3 || period_valid !== 1'b1) begin failures++; $display("FAIL rst_period got=%0d/%b exp=3/1", period, period_valid); end
  endtask

  initial begin
    test_reset();
    test_div4();
    test_lock_seq();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_held_high();
    test_clear_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
